// File: rtl/shifter_pkg.sv
// shifter_pkg: mode codes and FSM state encoding shared by the shifter files
package shifter_pkg;
    localparam logic [2:0] MODE_CLEAR = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SRL   = 3'b010;
    localparam logic [2:0] MODE_SLL   = 3'b011;
    localparam logic [2:0] MODE_SRA   = 3'b100;
    localparam logic [2:0] MODE_SERIN = 3'b101;
    localparam logic [2:0] MODE_ROR   = 3'b110;
    localparam logic [2:0] MODE_ROL   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one single-bit shift/rotate of the register for the given mode
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_r
);
    // CLEAR/LOAD never reach here as steps; they fall through to hold
    always_comb begin
        next_r = r;
        case (mode)
            MODE_SRL:   next_r = {1'b0, r[WIDTH-1:1]};
            MODE_SLL:   next_r = {r[WIDTH-2:0], 1'b0};
            MODE_SRA:   next_r = {r[WIDTH-1], r[WIDTH-1:1]};
            MODE_SERIN: next_r = {serial_in, r[WIDTH-1:1]};
            MODE_ROR:   next_r = {r[0], r[WIDTH-1:1]};
            MODE_ROL:   next_r = {r[WIDTH-2:0], r[WIDTH-1]};
            default:    next_r = r;
        endcase
    end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-step shift/rotate register with valid/ready command accept
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             out_valid
);
    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] w_next;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .r         (r_data),
        .mode      (r_mode),
        .serial_in (serial_in),
        .next_r    (w_next)
    );

    // FSM: accept in IDLE, one step per edge in SHIFT, single-cycle DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_CLEAR;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    if (mode == MODE_CLEAR) begin
                        r_data  <= '0;
                        r_state <= DONE;
                    end else if (mode == MODE_LOAD) begin
                        r_data  <= load_data;
                        r_state <= DONE;
                    end else if (amt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_mode  <= mode;
                        r_cnt   <= amt;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_data  <= w_next;
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= (r_cnt == 1) ? DONE : SHIFT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign data_out  = r_data;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed checks of seq_shifter at WIDTH 8 and WIDTH 16
module tb_seq_shifter;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_in_valid = 1'b0, a_serial_in = 1'b0;
    logic [2:0] a_mode = 3'd0;
    logic [3:0] a_amt = 4'd0;
    logic [7:0] a_load = 8'd0;
    logic       a_in_ready, a_busy, a_out_valid;
    logic [7:0] a_data;

    logic        b_in_valid = 1'b0, b_serial_in = 1'b0;
    logic [2:0]  b_mode = 3'd0;
    logic [3:0]  b_amt = 4'd0;
    logic [15:0] b_load = 16'd0;
    logic        b_in_ready, b_busy, b_out_valid;
    logic [15:0] b_data;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;
    logic [3:0] bits;

    seq_shifter #(.WIDTH(8), .AMT_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .amt(a_amt), .load_data(a_load), .serial_in(a_serial_in),
        .data_out(a_data), .busy(a_busy), .out_valid(a_out_valid)
    );

    seq_shifter #(.WIDTH(16), .AMT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .amt(b_amt), .load_data(b_load), .serial_in(b_serial_in),
        .data_out(b_data), .busy(b_busy), .out_valid(b_out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_cmd(input logic [2:0] m, input logic [3:0] n, input logic [7:0] d);
        a_in_valid = 1'b1;
        a_mode = m;
        a_amt = n;
        a_load = d;
        tick();
        a_in_valid = 1'b0;
    endtask

    // edges from accept (inclusive) until out_valid shows, bounded
    task automatic a_run(input string tag, input logic [2:0] m, input logic [3:0] n,
                         input logic [7:0] d, input int exp_edges, input logic [7:0] exp_data);
        int k;
        a_cmd(m, n, d);
        k = 1;
        while (!a_out_valid && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_lat"}, k, exp_edges);
        check({tag, "_data"}, a_data, exp_data);
        check({tag, "_rdy"}, a_in_ready, 1'b0);
        tick();
        check({tag, "_ovoff"}, a_out_valid, 1'b0);
        check({tag, "_idle"}, a_busy, 1'b0);
    endtask

    initial begin
        a_in_valid = 1'b1;
        a_mode = MODE_LOAD;
        a_load = 8'hFF;
        tick();
        tick();
        check("rst_data", a_data, 8'h00);
        check("rst_ov", a_out_valid, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_rdy", a_in_ready, 1'b1);
        rst = 1'b0;
        a_in_valid = 1'b0;
        tick();
        check("rst_noacc", a_busy, 1'b0);

        a_run("load_a5", MODE_LOAD, 4'd0, 8'hA5, 1, 8'hA5);

        a_run("load_81", MODE_LOAD, 4'd0, 8'h81, 1, 8'h81);
        a_cmd(MODE_SRA, 4'd3, 8'h00);
        check("sra_t0", a_data, 8'h81);
        check("sra_busy", a_busy, 1'b1);
        tick();
        check("sra_s1", a_data, 8'hC0);
        check("sra_ov1", a_out_valid, 1'b0);
        tick();
        check("sra_s2", a_data, 8'hE0);
        check("sra_ov2", a_out_valid, 1'b0);
        tick();
        check("sra_s3", a_data, 8'hF0);
        check("sra_ov3", a_out_valid, 1'b1);
        tick();
        check("sra_end", a_out_valid, 1'b0);

        a_run("load_01a", MODE_LOAD, 4'd0, 8'h01, 1, 8'h01);
        a_run("rol9", MODE_ROL, 4'd9, 8'h00, 10, 8'h02);
        a_run("load_01b", MODE_LOAD, 4'd0, 8'h01, 1, 8'h01);
        a_run("sll10", MODE_SLL, 4'd10, 8'h00, 11, 8'h00);
        a_run("load_ff", MODE_LOAD, 4'd0, 8'hFF, 1, 8'hFF);
        a_run("srl15", MODE_SRL, 4'd15, 8'h00, 16, 8'h00);
        a_run("clear", MODE_CLEAR, 4'd7, 8'h55, 1, 8'h00);

        a_serial_in = 1'b0;
        a_cmd(MODE_SERIN, 4'd4, 8'h00);
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            a_serial_in = bits[i];
            tick();
        end
        check("serin_data", a_data, 8'hD0);
        check("serin_ov", a_out_valid, 1'b1);
        a_serial_in = 1'b0;
        tick();

        a_run("load_96", MODE_LOAD, 4'd0, 8'h96, 1, 8'h96);
        a_cmd(MODE_ROR, 4'd5, 8'h00);
        tick();
        check("ror_s1", a_data, 8'h4B);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_data", a_data, 8'h00);
        check("abort_ov", a_out_valid, 1'b0);
        check("abort_rdy", a_in_ready, 1'b1);
        pulses = 0;
        repeat (3) begin
            tick();
            pulses += int'(a_out_valid);
        end
        check("abort_nopulse", pulses, 0);

        a_run("load_3c", MODE_LOAD, 4'd0, 8'h3C, 1, 8'h3C);
        a_in_valid = 1'b1;
        a_mode = MODE_SRL;
        a_amt = 4'd3;
        tick();
        a_mode = MODE_LOAD;
        a_load = 8'hFF;
        pulses = 0;
        repeat (3) begin
            tick();
            pulses += int'(a_out_valid);
        end
        check("hold_data", a_data, 8'h07);
        check("hold_pulses", pulses, 1);
        tick();
        a_in_valid = 1'b0;
        check("hold_ovoff", a_out_valid, 1'b0);
        check("hold_keep", a_data, 8'h07);
        tick();
        check("hold_noacc", a_busy, 1'b0);
        check("hold_keep2", a_data, 8'h07);

        b_in_valid = 1'b1;
        b_mode = MODE_LOAD;
        b_load = 16'h8001;
        tick();
        b_in_valid = 1'b0;
        check("w16_load_ov", b_out_valid, 1'b1);
        check("w16_load", b_data, 16'h8001);
        tick();
        b_in_valid = 1'b1;
        b_mode = MODE_ROR;
        b_amt = 4'd0;
        tick();
        b_in_valid = 1'b0;
        check("w16_ror0_ov", b_out_valid, 1'b1);
        check("w16_ror0", b_data, 16'h8001);
        tick();
        b_in_valid = 1'b1;
        b_amt = 4'd1;
        tick();
        b_in_valid = 1'b0;
        check("w16_ror1_wait", b_out_valid, 1'b0);
        tick();
        check("w16_ror1_ov", b_out_valid, 1'b1);
        check("w16_ror1", b_data, 16'hC000);
        tick();
        check("w16_idle", b_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-step shift/rotate register for the npc datapath experiments. It accepts a command (mode plus step count) over a valid/ready handshake. It applies one single-bit shift per clock until the count is exhausted, then pulses `out_valid`. It generalises the fixed 8-bit, one-step-per-clock shifter to any width, with a multi-step count, a busy/handshake protocol and a live serial input.

## Interface
- `WIDTH`, 8: register width in bits, ≥ 2.
- `AMT_W`, 4: width of the step-count field; counts 0 to 2^AMT_W−1 are legal, including counts above WIDTH.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: command present.
- `in_ready` output 1: block can accept a command; equals (state == IDLE).
- `mode` input 3: operation code, sampled on accept.
- `amt` input AMT_W: step count, sampled on accept.
- `load_data` input WIDTH: value for LOAD, sampled on accept.
- `serial_in` input 1: fill bit for SERIN mode, sampled live at every step edge.
- `data_out` output WIDTH: current register contents, always visible.
- `busy` output 1: state != IDLE.
- `out_valid` output 1: one-cycle pulse, command complete, `data_out` final.

## Operation
- Mode codes, with r = register:
  - 000 CLEAR: r = 0.
  - 001 LOAD: r = `load_data`.
  - 010 SRL: {0, r[W−1:1]}.
  - 011 SLL: {r[W−2:0], 0}.
  - 100 SRA: {r[W−1], r[W−1:1]}.
  - 101 SERIN: {serial_in, r[W−1:1]}.
  - 110 ROR: {r[0], r[W−1:1]}.
  - 111 ROL: {r[W−2:0], r[W−1]}.
- CLEAR and LOAD ignore `amt` and always complete in one update.
- Shift modes (010–111) apply exactly `amt` single-bit steps, one per clock.
  - Counts ≥ WIDTH are not saturated.
  - SRL/SLL go to zero; rotates wrap modulo WIDTH; SRA fills with sign.
- Accept happens when `in_valid && in_ready` at a rising edge. `in_valid` while busy is ignored (not queued).
- State machine states: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - CLEAR/LOAD: update r, go to DONE.
  - Shift with `amt` == 0: r unchanged, go to DONE.
  - Shift with `amt` ≥ 1: latch mode, cnt = `amt`, go to SHIFT.
- SHIFT: each edge applies one step and decrements cnt. The edge where cnt == 1 applies the last step and goes to DONE.
- DONE: `out_valid` = 1 for this single cycle; next edge returns to IDLE unconditionally.
- Reset: while `rst` is high, state = IDLE, r = 0, cnt = 0.
  - Reset mid-SHIFT aborts with no `out_valid`.
  - A command presented in a cycle with `rst` high is not accepted.

## Timing
- Reset values:
  - `data_out` = 0, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 1, but commands are blocked by `rst`.
- Latency, with accept at edge T:
  - CLEAR/LOAD/`amt` = 0: `out_valid` high in cycle T+1.
  - Shift with `amt` = N ≥ 1: step k lands at edge T+k, and `out_valid` is high in cycle T+N+1.
- `in_ready` low from cycle T+1 through the DONE cycle. Next accept is possible at the edge ending the first IDLE cycle, giving throughput of one command per N+2 cycles (2 for non-shift).
- `data_out` updates only at step or load edges and is stable while `out_valid` is high.
- `serial_in` is sampled at each step edge, not at accept.
- No backpressure on output; `out_valid` is never held.

## Structure
- Package `shifter_pkg`:
  - mode constants MODE_CLEAR … MODE_ROL.
  - state enum IDLE/SHIFT/DONE.
- Sub-module `shift_step`: purely combinational, parameter WIDTH.
  - Inputs: r, mode, serial_in.
  - Output: the next value after one step.
  - It is instantiated once in `seq_shifter`, which holds the FSM, counter and register.
- No simulation `$display` in synthesised RTL.

## Test plan
- Reset then LOAD 8'hA5 → `out_valid` one cycle after accept, `data_out` = A5, `busy` drops the next cycle.
- With r = 8'h81, SRA `amt` = 3 → steps C0, E0, F0 at edges T+1..T+3, `out_valid` in T+4.
- With r = 8'h01, ROL `amt` = 9 → 8'h02; SLL `amt` = 10 → 8'h00. Checks counts above WIDTH.
- SERIN `amt` = 4 from r = 0, with `serial_in` = 1,0,1,1 at successive step edges → `data_out` = 8'hD0.
- Assert `rst` in the 2nd step of ROR `amt` = 5 → `data_out` = 0 the next cycle, no `out_valid`, `in_ready` = 1. Hold `in_valid` during busy → ignored, no extra `out_valid`.
- WIDTH = 16 instance, LOAD 16'h8001 then ROR `amt` = 0 → `out_valid` next cycle, value unchanged; then ROR `amt` = 1 → 16'hC000.
